// File: rtl/seg7_msg_scroller.sv
// Seven-segment status message driver: one of four fixed 8-character messages shown
// static, blinking or scrolling across NUM_DIGITS digits, stepped by an internal tick divider.
module seg7_msg_scroller #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned TICK_DIV   = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              msg,
    input  logic [1:0]              mode,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    step
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CntMax = CW'(TICK_DIV - 1);

    localparam logic [1:0] ModeBlink  = 2'd1;
    localparam logic [1:0] ModeScroll = 2'd2;

    localparam logic [6:0] CharBlank = 7'b0000000;
    localparam logic [6:0] CharO     = 7'b1111110;
    localparam logic [6:0] CharP     = 7'b1100111;
    localparam logic [6:0] CharE     = 7'b1001111;
    localparam logic [6:0] CharN     = 7'b1110110;
    localparam logic [6:0] CharC     = 7'b1001110;
    localparam logic [6:0] CharL     = 7'b0001110;
    localparam logic [6:0] CharS     = 7'b1011011;
    localparam logic [6:0] CharR     = 7'b0000101;

    function automatic logic [6:0] rom_char(input logic [1:0] m, input logic [2:0] idx);
        logic [6:0] c;
        c = CharBlank;
        unique case (m)
            2'd0: c = CharBlank;
            2'd1: begin
                case (idx)
                    3'd0:    c = CharO;
                    3'd1:    c = CharP;
                    3'd2:    c = CharE;
                    3'd3:    c = CharN;
                    default: c = CharBlank;
                endcase
            end
            2'd2: begin
                case (idx)
                    3'd0:    c = CharC;
                    3'd1:    c = CharL;
                    3'd2:    c = CharO;
                    3'd3:    c = CharS;
                    3'd4:    c = CharE;
                    default: c = CharBlank;
                endcase
            end
            2'd3: begin
                case (idx)
                    3'd0:    c = CharE;
                    3'd1:    c = CharR;
                    3'd2:    c = CharR;
                    default: c = CharBlank;
                endcase
            end
        endcase
        return c;
    endfunction

    logic [1:0]              msg_q, mode_q, msg_d, mode_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [2:0]              pos, pos_d;
    logic                    phase, phase_d;
    logic                    step_d;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic                    chg, tick;

    assign chg  = (msg != msg_q) || (mode != mode_q);
    assign tick = (cnt == CntMax);

    always_comb begin
        msg_d   = msg_q;
        mode_d  = mode_q;
        cnt_d   = cnt;
        pos_d   = pos;
        phase_d = phase;
        step_d  = 1'b0;
        if (chg) begin
            // A tick coinciding with an input change is dropped so the new frame starts clean.
            msg_d   = msg;
            mode_d  = mode;
            cnt_d   = '0;
            pos_d   = '0;
            phase_d = 1'b1;
        end else begin
            step_d = tick;
            cnt_d  = tick ? '0 : cnt + CW'(1);
            if (tick && mode_q == ModeScroll) pos_d = pos + 3'd1;
            if (tick && mode_q == ModeBlink) phase_d = ~phase;
            if (mode_q != ModeScroll) pos_d = '0;
            if (mode_q != ModeBlink) phase_d = 1'b1;
        end
    end

    // Output frame is built from registered state only, so seg never sees raw inputs.
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_d[7*(NUM_DIGITS-1-i) +: 7] = rom_char(msg_q, pos + 3'(i));
        end
        if (mode_q == ModeBlink && !phase) seg_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q  <= '0;
            mode_q <= '0;
            cnt    <= '0;
            pos    <= '0;
            phase  <= 1'b1;
            step   <= 1'b0;
            seg    <= '0;
        end else begin
            msg_q  <= msg_d;
            mode_q <= mode_d;
            cnt    <= cnt_d;
            pos    <= pos_d;
            phase  <= phase_d;
            step   <= step_d;
            seg    <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Scoreboard bench for seg7_msg_scroller: stimulus queues cycle-stamped expected frames,
// a negedge monitor pops and compares them against 6-, 8- and 1-digit instances.
module tb_seg7_msg_scroller;

    localparam int unsigned TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  msg = 2'd0;
    logic [1:0]  mode = 2'd0;
    logic [41:0] seg6;
    logic [55:0] seg8;
    logic [6:0]  seg1;
    logic        step6, step8, step1;

    seg7_msg_scroller #(.NUM_DIGITS(6), .TICK_DIV(TD)) u6 (
        .clk(clk), .rst(rst), .msg(msg), .mode(mode), .seg(seg6), .step(step6)
    );
    seg7_msg_scroller #(.NUM_DIGITS(8), .TICK_DIV(TD)) u8 (
        .clk(clk), .rst(rst), .msg(msg), .mode(mode), .seg(seg8), .step(step8)
    );
    seg7_msg_scroller #(.NUM_DIGITS(1), .TICK_DIV(TD)) u1 (
        .clk(clk), .rst(rst), .msg(msg), .mode(mode), .seg(seg1), .step(step1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          dut;
        logic [55:0] seg;
        logic        step;
        string       name;
    } exp_t;

    exp_t  q[$];
    int    checks = 0;
    int    failures = 0;
    string mtxt[4] = '{"        ", "OPEN    ", "CLOSE   ", "Err     "};

    localparam logic [41:0] OpenLit = 42'b1111110_1100111_1001111_1110110_0000000_0000000;

    function automatic logic [6:0] chr(input byte c);
        case (c)
            "O":     return 7'b1111110;
            "P":     return 7'b1100111;
            "E":     return 7'b1001111;
            "N":     return 7'b1110110;
            "C":     return 7'b1001110;
            "L":     return 7'b0001110;
            "S":     return 7'b1011011;
            "r":     return 7'b0000101;
            default: return 7'b0000000;
        endcase
    endfunction

    // Frame of n digits starting at message character p, digit 0 in the top bits.
    function automatic logic [55:0] frame(input int m, input int p, input int n);
        logic [55:0] r;
        string       s;
        r = '0;
        s = mtxt[m];
        for (int i = 0; i < n; i++) r = {r[48:0], chr(s[(p + i) % 8])};
        return r;
    endfunction

    task automatic expect_at(input int dc, input int dut, input logic [55:0] s,
                             input logic st, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.dut  = dut;
        e.seg  = s;
        e.step = st;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] m, input logic [1:0] md);
        msg  = m;
        mode = md;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial forever begin
        exp_t        e;
        logic [55:0] act;
        logic        ast;
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e   = q.pop_front();
            act = (e.dut == 8) ? seg8 : (e.dut == 1) ? {49'b0, seg1} : {14'b0, seg6};
            ast = (e.dut == 8) ? step8 : (e.dut == 1) ? step1 : step6;
            checks++;
            if (e.cyc != cyc || act !== e.seg || ast !== e.step) begin
                failures++;
                $display("FAIL %s (dut%0d cyc %0d/%0d): got seg=%h step=%b, want seg=%h step=%b",
                         e.name, e.dut, cyc, e.cyc, act, ast, e.seg, e.step);
            end
        end
    end

    initial begin
        // Power-on reset, then static OPEN.
        edges(3);
        checks++;
        if (seg6 !== 42'h0 || step6 !== 1'b0) begin
            failures++;
            $display("FAIL direct_reset6: seg=%h step=%b", seg6, step6);
        end
        checks++;
        if (seg8 !== 56'h0 || step8 !== 1'b0) begin
            failures++;
            $display("FAIL direct_reset8: seg=%h step=%b", seg8, step8);
        end
        expect_at(0, 6, 56'h0, 1'b0, "reset_state6");
        expect_at(0, 8, 56'h0, 1'b0, "reset_state8");
        rst = 1'b0;
        drive(2'd1, 2'd0);
        expect_at(2, 6, {14'b0, OpenLit}, 1'b0, "open_static_lit");
        expect_at(2, 8, frame(1, 0, 8), 1'b0, "open_static8");
        expect_at(2, 1, frame(1, 0, 1), 1'b0, "open_static1");
        expect_at(4, 6, frame(1, 0, 6), 1'b0, "no_early_step");
        expect_at(5, 6, frame(1, 0, 6), 1'b1, "first_step");
        edges(6);

        // Blink CLOSE.
        drive(2'd2, 2'd1);
        expect_at(2, 6, frame(2, 0, 6), 1'b0, "blink_on");
        expect_at(5, 6, frame(2, 0, 6), 1'b1, "blink_step");
        expect_at(6, 6, 56'h0, 1'b0, "blink_off");
        expect_at(9, 6, 56'h0, 1'b1, "blink_step2");
        expect_at(10, 6, frame(2, 0, 6), 1'b0, "blink_back");
        edges(11);

        // Scroll OPEN through a full wrap, then change message mid-count at pos 3, cnt 2.
        drive(2'd1, 2'd2);
        expect_at(2, 6, frame(1, 0, 6), 1'b0, "scroll_pos0");
        expect_at(5, 6, frame(1, 0, 6), 1'b1, "scroll_step1");
        expect_at(6, 6, frame(1, 1, 6), 1'b0, "scroll_pos1");
        expect_at(6, 8, frame(1, 1, 8), 1'b0, "scroll_pos1_8");
        expect_at(6, 1, frame(1, 1, 1), 1'b0, "scroll_pos1_1");
        expect_at(10, 1, frame(1, 2, 1), 1'b0, "scroll_pos2_1");
        expect_at(30, 6, frame(1, 7, 6), 1'b0, "scroll_pos7");
        expect_at(30, 1, frame(1, 7, 1), 1'b0, "scroll_pos7_1");
        expect_at(34, 6, frame(1, 0, 6), 1'b0, "scroll_wrap");
        expect_at(47, 6, frame(1, 3, 6), 1'b0, "scroll_pos3");
        edges(47);
        drive(2'd3, 2'd2);
        expect_at(2, 6, frame(3, 0, 6), 1'b0, "change_err");
        expect_at(4, 6, frame(3, 0, 6), 1'b0, "change_no_step");
        expect_at(5, 6, frame(3, 0, 6), 1'b1, "change_step");
        expect_at(6, 6, frame(3, 1, 6), 1'b0, "change_pos1");
        edges(7);

        // Static Err, then switch to blink on the edge where the tick would fire.
        drive(2'd3, 2'd0);
        expect_at(2, 6, frame(3, 0, 6), 1'b0, "err_static");
        expect_at(2, 8, frame(3, 0, 8), 1'b0, "err_static8");
        edges(4);
        drive(2'd3, 2'd1);
        expect_at(1, 6, frame(3, 0, 6), 1'b0, "coinc_no_step");
        expect_at(2, 6, frame(3, 0, 6), 1'b0, "coinc_phase");
        expect_at(4, 6, frame(3, 0, 6), 1'b0, "coinc_wait");
        expect_at(5, 6, frame(3, 0, 6), 1'b1, "coinc_step");
        expect_at(6, 6, 56'h0, 1'b0, "coinc_blink_off");
        edges(7);

        // Asynchronous reset while scrolling, just after pos becomes 5.
        drive(2'd1, 2'd2);
        expect_at(20, 6, frame(1, 4, 6), 1'b0, "pre_reset_pos4");
        edges(21);
        rst = 1'b1;
        #1;
        checks++;
        if (seg1 !== 7'h0 || step1 !== 1'b0) begin
            failures++;
            $display("FAIL direct_async_reset1: seg=%h step=%b", seg1, step1);
        end
        expect_at(0, 6, 56'h0, 1'b0, "async_reset6");
        expect_at(0, 1, 56'h0, 1'b0, "async_reset1");
        edges(2);
        expect_at(0, 6, 56'h0, 1'b0, "reset_hold");
        rst = 1'b0;
        drive(2'd1, 2'd0);
        expect_at(1, 6, 56'h0, 1'b0, "post_reset_latency");
        expect_at(2, 6, {14'b0, OpenLit}, 1'b0, "post_reset_open");
        expect_at(2, 8, frame(1, 0, 8), 1'b0, "post_reset_open8");
        edges(6);

        edges(2);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: never compared, due cyc %0d, now cyc %0d", e.name, e.cyc, cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_msg_scroller.md
# seg7_msg_scroller

Parametrised successor to the door-lock status decoder. It selects one of four fixed 8-character status messages (blank, OPEN, CLOSE, Err) and drives NUM_DIGITS seven-segment digits. Three display modes are supported: static, blink and scroll, all timed by an internal tick divider. It sits between the door-lock controller's status outputs and the board's seven-segment bank, and presents registered, glitch-free segment outputs.

## Interface
- NUM_DIGITS, 6: number of digits driven; legal range 1..8.
- TICK_DIV, 25_000_000: clock cycles per display step (blink toggle or scroll shift); must be >= 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- msg  in  2  message select: 0 = blank, 1 = OPEN, 2 = CLOSE, 3 = Err.
- mode  in  2  0 = static, 1 = blink, 2 = scroll, 3 = treated as static.
- seg  out  7*NUM_DIGITS  segment bus. Digit 0 (leftmost) is seg[7*NUM_DIGITS-1 -: 7]. Each digit is {a,b,c,d,e,f,g} with a at the MSB; 1 = lit.
- step  out  1  one-cycle pulse on every display step; used for test and for the buzzer sync.

## Operation
- Character patterns:
  - blank 0000000
  - O 1111110
  - P 1100111
  - E 1001111
  - N 1110110
  - C 1001110
  - L 0001110
  - S 1011011
  - r 0000101
- Message ROM, characters 0..7, with blanks padding the right:
  - msg0 = 8 blanks
  - msg1 = "OPEN    "
  - msg2 = "CLOSE   "
  - msg3 = "Err     "
- State registers:
  - msg_q and mode_q hold the registered copies of msg and mode.
  - cnt is the tick divider, ceil(log2(TICK_DIV)) bits.
  - pos is the scroll position, 3 bits, mod 8.
  - phase is the blink phase; 1 = visible.
- Tick: cnt counts 0..TICK_DIV-1. When cnt == TICK_DIV-1, tick = 1 and cnt wraps to 0. step is the registered tick.
- Change detect: if msg != msg_q or mode != mode_q at a clock edge, that edge does the following:
  - loads msg_q and mode_q;
  - clears cnt to 0 and pos to 0;
  - sets phase to 1.
  - A tick landing on the same edge is discarded, and step stays 0 on the next cycle.
- Static mode: digit i shows ROM character i.
- Blink mode: each tick toggles phase. While phase = 0, seg = all zeros; while phase = 1, the output matches static.
- Scroll mode: each tick does pos <= pos+1 mod 8, wrapping 7 -> 0. Digit i shows ROM character (pos+i) mod 8.
- Modes other than blink keep phase at 1. Modes other than scroll keep pos at 0.
- msg0 in any mode gives all zeros; counters still run and step still pulses.
- seg is a register computed from msg_q, mode_q, pos and phase. No combinational path runs from the inputs to seg.

## Timing
- Reset (asynchronous, immediate):
  - seg = 0, step = 0;
  - msg_q = 0, mode_q = 0;
  - cnt = 0, pos = 0, phase = 1.
- First edge after rst falls: normal counting resumes from cnt = 0.
- Input latency: inputs change before edge N. Edge N loads state, and seg shows the new content after edge N+1. The first step pulse is high in the cycle following edge N+TICK_DIV.
- Step cadence: after a change or reset, tick fires on every TICK_DIV-th edge. seg reflects each step one cycle after step rises.
- Reset mid-operation: all state returns to its reset values regardless of mode or pos. There is no partial-frame output.
- Input changes shorter than one clock may be missed. The block does not need to catch them.

## Test plan
- Reset while scrolling at pos = 5 → seg = 0 and step = 0 immediately without a clock edge. After release with msg = 1, mode = 0: seg = 1111110_1100111_1001111_1110110_0000000_0000000 two edges later.
- TICK_DIV = 4, NUM_DIGITS = 6, msg = 2, mode = 1:
  - seg shows C L O S E blank;
  - after 4 edges, step pulses and seg becomes all zeros;
  - after 4 more edges, seg shows C L O S E blank again.
- TICK_DIV = 4, msg = 1, mode = 2:
  - after the first step, digits show P E N blank blank blank;
  - after 7 steps, pos = 7 and digit 0 is blank, digit 1 is O;
  - the 8th step wraps pos to 0 and the original frame returns.
- Mid-count change, with cnt = 2 and pos = 3 in scroll: switch msg 1 → 3. On the next edge pos = 0 and cnt = 0. seg shows E r r blank blank blank. The next step comes exactly TICK_DIV edges after the change.
- Tick coincident with a mode change (static → blink on the edge where cnt = TICK_DIV-1) → step stays 0, phase stays 1, and the counter restarts at 0.
- NUM_DIGITS = 8, msg = 3, mode = 0 → the 56-bit seg shows E r r followed by 5 blanks. NUM_DIGITS = 1, mode = 2 → digit 0 cycles through the 8 message characters, one per tick.
